// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host-to-device transmitter: FSM states,
// timing multipliers (in sysclk_frequency units) and frame layout.
package ps2_host_tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INHIBIT,
      ST_RTS,
      ST_WAIT_FIRST,
      ST_SHIFT,
      ST_ACK,
      ST_WAIT_IDLE,
      ST_ERR
   } tx_state_t;

   // sysclk_frequency is in 100 kHz units, so these give 120 us / 15 ms / 2 ms
   localparam int INHIBIT_MULT   = 12;
   localparam int FIRST_CLK_MULT = 1500;
   localparam int FRAME_MULT     = 200;

   // start + 8 data + parity + stop; the device ACK arrives on the 11th falling edge
   localparam int FRAME_BITS     = 11;
   localparam int LAST_DATA_EDGE = FRAME_BITS - 2;

   // Shift register image: {odd parity, data}, sent LSB first
   function automatic logic [8:0] frame_word(input logic [7:0] d);
      return {~^d, d};
   endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command-side handshake of the PS/2 host transmitter.
// tx_req is accepted only while the block is idle (tx_busy low, no done/error pulse this cycle); no queueing.
interface ps2_host_tx_if;
   logic [7:0] tx_data;
   logic       tx_req;
   logic       tx_busy;
   logic       tx_done;
   logic       tx_error;

   modport master (output tx_data, output tx_req,
                   input  tx_busy, input tx_done, input tx_error);
   modport slave  (input  tx_data, input tx_req,
                   output tx_busy, output tx_done, output tx_error);
endinterface

// File: rtl/ps2_line_filter.sv
// Synchroniser plus stability filter for one PS/2 line, with a one-cycle
// strobe on each filtered falling edge. Shared with the receive path.
module ps2_line_filter #(
   parameter int filter_len = 8
) (
   input  logic clk,
   input  logic reset_in,
   input  logic line_in,
   output logic line_f,
   output logic fall
);

   localparam int CW = $clog2(filter_len + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(filter_len - 1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;

   // Idle PS/2 lines float high, so reset to 1 to avoid a spurious edge
   always_ff @(posedge clk or negedge reset_in) begin
      if (!reset_in) begin
         sync1  <= 1'b1;
         sync2  <= 1'b1;
         line_f <= 1'b1;
         cnt    <= '0;
         fall   <= 1'b0;
      end else begin
         sync1 <= line_in;
         sync2 <= sync1;
         fall  <= 1'b0;
         if (sync2 == line_f) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            line_f <= sync2;
            cnt    <= '0;
            fall   <= line_f;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, bit shifting on
// device clock falling edges, odd parity and device ACK check.
module ps2_host_tx
   import ps2_host_tx_pkg::*;
#(
   parameter int sysclk_frequency = 1330,
   parameter int filter_len       = 8
) (
   input  logic               clk,
   input  logic               reset_in,
   ps2_host_tx_if.slave       tx,
   input  logic               ps2_clk_in,
   input  logic               ps2_dat_in,
   output logic               ps2_clk_oe,
   output logic               ps2_dat_oe,
   output tx_state_t          state_dbg
);

   localparam int INHIBIT_CYC = sysclk_frequency * INHIBIT_MULT;
   localparam int FIRST_CYC   = sysclk_frequency * FIRST_CLK_MULT;
   localparam int FRAME_CYC   = sysclk_frequency * FRAME_MULT;
   localparam int TW          = $clog2(FIRST_CYC + 1);

   localparam logic [TW-1:0] INHIBIT_LAST = TW'(INHIBIT_CYC - 1);
   localparam logic [TW-1:0] FIRST_LAST   = TW'(FIRST_CYC - 1);
   localparam logic [TW-1:0] FRAME_LAST   = TW'(FRAME_CYC - 1);

   logic rst_meta;
   logic rst_n;

   // Reset asserts asynchronously but is released on a clock edge
   always_ff @(posedge clk or negedge reset_in) begin
      if (!reset_in) begin
         rst_meta <= 1'b0;
         rst_n    <= 1'b0;
      end else begin
         rst_meta <= 1'b1;
         rst_n    <= rst_meta;
      end
   end

   logic clk_f, clk_fall;
   logic dat_f, dat_fall_unused;

   ps2_line_filter #(.filter_len(filter_len)) u_clk_filter (
      .clk      (clk),
      .reset_in (rst_n),
      .line_in  (ps2_clk_in),
      .line_f   (clk_f),
      .fall     (clk_fall)
   );

   ps2_line_filter #(.filter_len(filter_len)) u_dat_filter (
      .clk      (clk),
      .reset_in (rst_n),
      .line_in  (ps2_dat_in),
      .line_f   (dat_f),
      .fall     (dat_fall_unused)
   );

   tx_state_t     state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [3:0]    edge_q,  edge_d;
   logic [8:0]    shift_q, shift_d;
   logic          dat_oe_q, dat_oe_d;
   logic          frame_expired;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         timer_q  <= '0;
         edge_q   <= '0;
         shift_q  <= '0;
         dat_oe_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         edge_q   <= edge_d;
         shift_q  <= shift_d;
         dat_oe_q <= dat_oe_d;
      end
   end

   assign frame_expired = (timer_q == FRAME_LAST);

   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q + 1'b1;
      edge_d   = edge_q;
      shift_d  = shift_q;
      dat_oe_d = dat_oe_q;
      unique case (state_q)
         ST_IDLE: begin
            timer_d  = '0;
            edge_d   = '0;
            dat_oe_d = 1'b0;
            if (tx.tx_req) begin
               shift_d = frame_word(tx.tx_data);
               state_d = ST_INHIBIT;
            end
         end
         ST_INHIBIT: begin
            if (timer_q == INHIBIT_LAST) begin
               dat_oe_d = 1'b1;
               state_d  = ST_RTS;
            end
         end
         ST_RTS: begin
            timer_d = '0;
            state_d = ST_WAIT_FIRST;
         end
         ST_WAIT_FIRST: begin
            if (clk_fall) begin
               dat_oe_d = ~shift_q[0];
               shift_d  = shift_q >> 1;
               edge_d   = 4'd1;
               timer_d  = '0;
               state_d  = ST_SHIFT;
            end else if (timer_q == FIRST_LAST) begin
               dat_oe_d = 1'b0;
               state_d  = ST_ERR;
            end
         end
         ST_SHIFT: begin
            if (frame_expired) begin
               dat_oe_d = 1'b0;
               state_d  = ST_ERR;
            end else if (clk_fall) begin
               edge_d = edge_q + 1'b1;
               // Parity already on the line: this edge releases data as the stop bit
               if (edge_q == 4'(LAST_DATA_EDGE)) begin
                  dat_oe_d = 1'b0;
                  state_d  = ST_ACK;
               end else begin
                  dat_oe_d = ~shift_q[0];
                  shift_d  = shift_q >> 1;
               end
            end
         end
         ST_ACK: begin
            if (frame_expired) begin
               state_d = ST_ERR;
            end else if (clk_fall) begin
               edge_d  = edge_q + 1'b1;
               state_d = dat_f ? ST_ERR : ST_WAIT_IDLE;
            end
         end
         ST_WAIT_IDLE: begin
            if (frame_expired) begin
               state_d = ST_ERR;
            end else if (clk_f && dat_f) begin
               state_d = ST_IDLE;
            end
         end
         ST_ERR: begin
            dat_oe_d = 1'b0;
            state_d  = ST_IDLE;
         end
         default: begin
            dat_oe_d = 1'b0;
            state_d  = ST_IDLE;
         end
      endcase
   end

   assign ps2_clk_oe  = (state_q == ST_INHIBIT) || (state_q == ST_RTS);
   assign ps2_dat_oe  = dat_oe_q;
   assign tx.tx_busy  = (state_q != ST_IDLE);
   assign tx.tx_done  = (state_q == ST_WAIT_IDLE) && !frame_expired && clk_f && dat_f;
   assign tx.tx_error = (state_q == ST_ERR);
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx at 1 MHz with a 12.5 kHz device model on open-collector lines.
module tb_ps2_host_tx;
   import ps2_host_tx_pkg::*;

   localparam int SYSCLK = 10;
   localparam int FILT   = 8;
   localparam int HALF   = 40;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset_in = 1'b0;
   always #5 clk = ~clk;

   ps2_host_tx_if tx_if ();
   logic      ps2_clk_oe, ps2_dat_oe;
   logic      ps2_clk_in, ps2_dat_in;
   tx_state_t state_dbg;
   logic      dev_clk = 1'b1;
   logic      dev_dat = 1'b1;
   logic      glitch_n = 1'b1;

   assign ps2_clk_in = dev_clk & glitch_n & ~ps2_clk_oe;
   assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

   ps2_host_tx #(.sysclk_frequency(SYSCLK), .filter_len(FILT)) dut (
      .clk        (clk),
      .reset_in   (reset_in),
      .tx         (tx_if),
      .ps2_clk_in (ps2_clk_in),
      .ps2_dat_in (ps2_dat_in),
      .ps2_clk_oe (ps2_clk_oe),
      .ps2_dat_oe (ps2_dat_oe),
      .state_dbg  (state_dbg)
   );

   // ---------------- scoreboard / monitors ----------------
   int tests = 0;
   int failed = 0;
   int done_cnt = 0, err_cnt = 0, both_cnt = 0;
   int low_run = 0, last_low_run = 0;
   logic [10:0] exp_q[$];

   always @(negedge clk) begin
      if (tx_if.tx_done) done_cnt++;
      if (tx_if.tx_error) err_cnt++;
      if (tx_if.tx_done && tx_if.tx_error) both_cnt++;
      if (ps2_clk_oe) low_run++;
      else if (low_run != 0) begin
         last_low_run = low_run;
         low_run = 0;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Frame as the device sees it: start 0, data LSB first, odd parity, stop 1
   function automatic logic [10:0] ref_frame(input logic [7:0] d);
      logic par;
      par = ($countones(d) % 2) == 0;
      return {1'b1, par, d, 1'b0};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic request(input logic [7:0] d);
      tx_if.tx_data = d;
      tx_if.tx_req  = 1'b1;
      @(negedge clk);
      tx_if.tx_req  = 1'b0;
   endtask

   task automatic device_frame(input int edges, input bit ack, input bit glitch,
                               output logic [10:0] got);
      int n;
      n = 0;
      got = '0;
      while (!(ps2_clk_in && !ps2_dat_in) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("bfm_start_timeout", 32'(n >= 2000), 32'd0);
      if (n >= 2000) return;
      cycles(20);
      got[0] = ps2_dat_in;
      for (int e = 1; e <= edges; e++) begin
         if (e == 11 && ack) begin
            dev_dat = 1'b0;
            cycles(20);
         end
         dev_clk = 1'b0;
         cycles(HALF);
         dev_clk = 1'b1;
         if (glitch) begin
            cycles(10);
            glitch_n = 1'b0;
            cycles(3);
            glitch_n = 1'b1;
            cycles(7);
         end else begin
            cycles(20);
         end
         if (e <= 10) got[e] = ps2_dat_in;
         if (e == 11) dev_dat = 1'b1;
         cycles(20);
      end
   endtask

   task automatic wait_outcome(input int d0, input int e0);
      int n;
      n = 0;
      while (done_cnt == d0 && err_cnt == e0 && n < 3000) begin
         cycles(1);
         n++;
      end
      check("outcome_timeout", 32'(n >= 3000), 32'd0);
   endtask

   task automatic send_frame(input logic [7:0] d, input string tag, output logic [10:0] got);
      int d0, e0;
      logic [10:0] exp;
      d0 = done_cnt;
      e0 = err_cnt;
      exp_q.push_back(ref_frame(d));
      request(d);
      check({tag, "_busy"}, 32'(tx_if.tx_busy), 32'd1);
      device_frame(11, 1'b1, 1'b0, got);
      wait_outcome(d0, e0);
      exp = exp_q.pop_front();
      check({tag, "_bits"}, 32'(got), 32'(exp));
      check({tag, "_done"}, 32'(done_cnt - d0), 32'd1);
      check({tag, "_err"}, 32'(err_cnt - e0), 32'd0);
      cycles(1);
      check({tag, "_idle"}, 32'(tx_if.tx_busy), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // ---------------- tests ----------------
   initial begin
      logic [10:0] got;
      logic [10:0] exp;
      logic [7:0]  d;
      int d0, e0, n;

      tx_if.tx_req  = 1'b0;
      tx_if.tx_data = 8'h00;
      cycles(3);
      check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
      check("rst_dat_oe", 32'(ps2_dat_oe), 32'd0);
      check("rst_busy", 32'(tx_if.tx_busy), 32'd0);
      check("rst_done", 32'(tx_if.tx_done), 32'd0);
      check("rst_err", 32'(tx_if.tx_error), 32'd0);
      check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
      reset_in = 1'b1;
      cycles(5);

      // 1: LED command, inhibit length, literal frame
      send_frame(8'hED, "t1", got);
      check("t1_inhibit_ge120", 32'(last_low_run >= 120), 32'd1);
      check("t1_literal", 32'(got), 32'({1'b1, 1'b1, 8'hED, 1'b0}));

      // 2: parity extremes and random back-to-back bytes
      send_frame(8'h01, "t2_01", got);
      check("t2_01_parity", 32'(got[9]), 32'd0);
      send_frame(8'hFF, "t2_ff", got);
      check("t2_ff_parity", 32'(got[9]), 32'd1);
      for (int i = 0; i < 4; i++) begin
         d = 8'($urandom_range(0, 255));
         send_frame(d, "t2_rand", got);
      end

      // 3: device never clocks
      d0 = done_cnt;
      e0 = err_cnt;
      request(8'hA0);
      n = 0;
      while (ps2_clk_oe && n < 500) begin
         cycles(1);
         n++;
      end
      check("t3_release_timeout", 32'(n >= 500), 32'd0);
      n = 0;
      while (!tx_if.tx_error && n < 20000) begin
         cycles(1);
         n++;
      end
      check("t3_err_latency", 32'(n), 32'd15000);
      check("t3_clk_oe", 32'(ps2_clk_oe), 32'd0);
      check("t3_dat_oe", 32'(ps2_dat_oe), 32'd0);
      cycles(1);
      check("t3_busy", 32'(tx_if.tx_busy), 32'd0);
      check("t3_err_cnt", 32'(err_cnt - e0), 32'd1);
      check("t3_done_cnt", 32'(done_cnt - d0), 32'd0);

      // 4: device does not acknowledge
      d0 = done_cnt;
      e0 = err_cnt;
      request(8'h5A);
      device_frame(11, 1'b0, 1'b0, got);
      wait_outcome(d0, e0);
      check("t4_bits", 32'(got), 32'(ref_frame(8'h5A)));
      check("t4_err_cnt", 32'(err_cnt - e0), 32'd1);
      check("t4_done_cnt", 32'(done_cnt - d0), 32'd0);

      // 5: reset while bit 4 is on the line
      d0 = done_cnt;
      e0 = err_cnt;
      request(8'hA5);
      device_frame(5, 1'b1, 1'b0, got);
      check("t5_bit4_driven", 32'(ps2_dat_oe), 32'd1);
      check("t5_busy_before", 32'(tx_if.tx_busy), 32'd1);
      #2 reset_in = 1'b0;
      #1;
      check("t5_clk_oe", 32'(ps2_clk_oe), 32'd0);
      check("t5_dat_oe", 32'(ps2_dat_oe), 32'd0);
      check("t5_busy", 32'(tx_if.tx_busy), 32'd0);
      cycles(3);
      reset_in = 1'b1;
      cycles(5);
      check("t5_no_pulse", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
      send_frame(8'h55, "t5_after", got);

      // 6: stray requests and short clock glitches during a frame
      d0 = done_cnt;
      e0 = err_cnt;
      exp_q.push_back(ref_frame(8'hC3));
      request(8'hC3);
      fork
         device_frame(11, 1'b1, 1'b1, got);
         begin
            cycles(300);
            request(8'h3C);
            cycles(200);
            request(8'h81);
         end
      join
      wait_outcome(d0, e0);
      exp = exp_q.pop_front();
      check("t6_bits", 32'(got), 32'(exp));
      check("t6_done", 32'(done_cnt - d0), 32'd1);
      check("t6_err", 32'(err_cnt - e0), 32'd0);
      cycles(200);
      check("t6_no_queue_busy", 32'(tx_if.tx_busy), 32'd0);
      check("t6_no_queue_done", 32'(done_cnt - d0), 32'd1);

      check("never_both_pulses", 32'(both_cnt), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
